conv_layer_sequencer: RTL and testbench
=======================================

// Module: conv_layer_sequencer
// PURPOSE
// - Hardware replacement for the host conv flow: runs N conv layers back to back with no CPU in the loop.
// - Per layer: fetches a CSR descriptor from an external table and writes it to the accelerator CSR space over AXI-lite.
// - Then kicks the layer, polls the done bit and (optionally) accumulates the DMA/FSM performance counters.
// - Sits between the system CSR interconnect and the Vit_wrapper S_AXI port, in place of AXI_GP_Master_CPU.
// PARAMETERS
// CSR_AW         8    AXI-lite byte-address width (log2CSR_REG_NUM+2); register index i -> address {i,2'b00}
// NUM_CFG_REGS   26   config words per layer, written to register indices CFG_BASE_IDX..+NUM_CFG_REGS-1
// CFG_BASE_IDX   1    first config register index
// START_IDX      0    kick register: write 32'h1 starts the layer
// STATUS_IDX     0    status register: bit0=1 means layer done
// PERF_BASE_IDX  27   first perf counter index (27..30: dma_dat, dma_wt, fsm_dat, fsm_wt)
// NUM_PERF       4    perf counters read per layer
// MAX_LAYERS     16   layer capacity; table depth = MAX_LAYERS*NUM_CFG_REGS
// POLL_GAP       16   idle cycles between status reads
// TIMEOUT        2**24 poll cycles per layer before error
// PORTS
// clk            in   1     clock
// rst            in   1     synchronous, active-high reset
// start          in   1     1-cycle pulse, ignored while busy
// num_layers     in   5     layers to run (0..MAX_LAYERS), sampled on start
// desc_rd_en     out  1     table read strobe
// desc_rd_addr   out  $clog2(MAX_LAYERS*NUM_CFG_REGS)  word address = layer*NUM_CFG_REGS+reg
// desc_rd_data   in   32    config word, valid 1 cycle after desc_rd_en
// m_awvalid/m_awready/m_awaddr[CSR_AW]/m_awprot[3]  AXI-lite AW (prot=0)
// m_wvalid/m_wready/m_wdata[32]/m_wstrb[4]           AXI-lite W (strb=4'hF)
// m_bvalid/m_bready/m_bresp[2]                       AXI-lite B
// m_arvalid/m_arready/m_araddr[CSR_AW]/m_arprot[3]   AXI-lite AR
// m_rvalid/m_rready/m_rdata[32]/m_rresp[2]           AXI-lite R
// busy           out  1     sequence in progress
// done           out  1     1-cycle pulse at end of sequence (success or error)
// error          out  1     sticky until next accepted start
// err_code       out  2     0 none, 1 BRESP!=0, 2 RRESP!=0, 3 timeout
// layer_idx      out  5     layer currently running / layer where error occurred
// perf_sum       out  NUM_PERF*32  per-counter sums over the run, 32-bit saturating
// BEHAVIOUR
// - Reset: all valid/ready outputs, desc_rd_en, busy, done, error 0; err_code, layer_idx, perf_sum 0; FSM=IDLE.
// - Reset mid-transaction drops valids immediately; the CSR slave shares rst.
// - FSM: IDLE -> FETCH -> WR -> WB -> (next reg | KICK) -> KWR -> KB -> GAP -> POLL_AR -> POLL_R
//   -> (GAP | PERF_AR/PERF_R xNUM_PERF) -> NEXT -> (FETCH | FIN) -> IDLE.
// - IDLE: start && num_layers!=0 -> busy=1, clear perf_sum/error, layer_idx=0. start with num_layers=0 -> done next cycle, no bus traffic.
// - FETCH: desc_rd_en 1 cycle; data captured next cycle. Every write (WR/KWR) asserts AWVALID and WVALID in the same cycle.
// - Each valid deasserts independently on its own ready; BREADY=1 only in WB/KB; advance on BVALID.
// - Write phase takes >=3 cycles (AW/W, B, FETCH), so no back-to-back overlap; one outstanding transaction at a time.
// - Reads: ARVALID until ARREADY; RREADY=1 in *_R states, data taken on RVALID.
// - BRESP!=0 / RRESP!=0 -> error=1, err_code 1/2, go to FIN. No further transactions; perf_sum retains partial sums.
// - GAP counts POLL_GAP cycles. Timeout counter spans KB exit to status done; hitting TIMEOUT -> err_code 3, FIN.
// - Status rdata[0]=0 -> GAP; =1 -> perf reads (or NEXT).
// - perf_sum[k] += rdata, clamped at 32'hFFFF_FFFF.
// - NEXT: layer_idx++; equal to num_layers -> FIN. FIN: done=1 for 1 cycle, busy=0.
// - Valids never drop before handshake; addresses/data stable while valid.
// - start during busy: ignored, no effect on run.
// CONFIGURATION
// - CONV_SEQ_PERF_EN defined: perf readback performed per layer as above.
// - Not defined: PERF_AR/PERF_R states removed, status done -> NEXT directly, perf_sum tied 0.
// TESTING
// - 1 layer, table word[r]=r+100, zero-wait slave, done after 3 polls
//   -> 26 writes to addr 4..104 with data 100..125, then write 1 to addr 0, done pulse, error=0.
// - 3 layers, slave stalls AWREADY 5 cycles and WREADY 2
//   -> each write seen exactly once, AW/W valids drop independently, layer_idx ends 3.
// - PERF_EN, counters return 10,20,30,40 per layer x2 layers -> perf_sum = {80,60,40,20}.
// - Counter returns 32'hFFFF_FFF0 twice -> sum saturates at 32'hFFFF_FFFF.
// - BRESP=2'b10 on layer 1 write 5 -> error=1, err_code=1, layer_idx=1, done pulse, no further AW/AR.
// - Status never done with TIMEOUT=200 -> err_code=3.
// - rst asserted during WB -> all valids 0 next cycle, busy=0.
// - start with num_layers=0 -> done only.

Source files
------------

// File: rtl/conv_layer_sequencer_if.sv
// AXI-lite master/slave bundle between the conv layer sequencer and the accelerator CSR port.
interface conv_layer_sequencer_if #(
  parameter int CSR_AW = 8
);
  logic              awvalid;
  logic              awready;
  logic [CSR_AW-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [CSR_AW-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Runs N conv layers back to back: descriptor fetch, CSR writes, kick, status polling.
// Define CONV_SEQ_PERF_EN to read back and accumulate the per-layer performance counters.
module conv_layer_sequencer #(
  parameter int CSR_AW        = 8,
  parameter int NUM_CFG_REGS  = 26,
  parameter int CFG_BASE_IDX  = 1,
  parameter int START_IDX     = 0,
  parameter int STATUS_IDX    = 0,
  parameter int PERF_BASE_IDX = 27,
  parameter int NUM_PERF      = 4,
  parameter int MAX_LAYERS    = 16,
  parameter int POLL_GAP      = 16,
  parameter int TIMEOUT       = 2**24
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [4:0]                                   num_layers,
  output logic                                         desc_rd_en,
  output logic [$clog2(MAX_LAYERS*NUM_CFG_REGS)-1:0]   desc_rd_addr,
  input  logic [31:0]                                  desc_rd_data,
  conv_layer_sequencer_if.master                       m_axil,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         error,
  output logic [1:0]                                   err_code,
  output logic [4:0]                                   layer_idx,
  output logic [NUM_PERF*32-1:0]                       perf_sum
);
  localparam int IW  = CSR_AW - 2;
  localparam int DAW = $clog2(MAX_LAYERS*NUM_CFG_REGS);
  localparam int RW  = $clog2(NUM_CFG_REGS);
  localparam int GW  = $clog2(POLL_GAP + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR, S_WB, S_KWR, S_KB, S_GAP, S_POLL_AR, S_POLL_R,
`ifdef CONV_SEQ_PERF_EN
    S_PERF_AR, S_PERF_R,
`endif
    S_NEXT, S_FIN
  } state_t;

  function automatic logic [CSR_AW-1:0] csr_addr(input logic [IW-1:0] idx);
    return {idx, 2'b00};
  endfunction

  state_t            state_r;
  logic              fetch_ph_r;
  logic [RW-1:0]     reg_cnt_r;
  logic [GW-1:0]     gap_cnt_r;
  logic [TW-1:0]     tmo_cnt_r;
  logic [4:0]        num_layers_r;
  logic              desc_rd_en_r;
  logic [DAW-1:0]    desc_rd_addr_r;
  logic              awvalid_r;
  logic              wvalid_r;
  logic [CSR_AW-1:0] awaddr_r;
  logic [31:0]       wdata_r;
  logic              bready_r;
  logic              arvalid_r;
  logic [CSR_AW-1:0] araddr_r;
  logic              rready_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic [1:0]        err_code_r;
  logic [4:0]        layer_idx_r;

`ifdef CONV_SEQ_PERF_EN
  localparam int PW = (NUM_PERF > 1) ? $clog2(NUM_PERF) : 1;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [PW-1:0]         perf_idx_r;
  logic [NUM_PERF*32-1:0] perf_sum_r;
  assign perf_sum = perf_sum_r;
`else
  localparam logic [IW-1:0] unused_perf_base = IW'(PERF_BASE_IDX);
  logic unused_rdata_s;
  assign unused_rdata_s = ^m_axil.rdata[31:1];
  assign perf_sum = '0;
`endif

  // Sequencer FSM; every bus and status output comes straight from a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      fetch_ph_r     <= 1'b0;
      reg_cnt_r      <= '0;
      gap_cnt_r      <= '0;
      tmo_cnt_r      <= '0;
      num_layers_r   <= 5'd0;
      desc_rd_en_r   <= 1'b0;
      desc_rd_addr_r <= '0;
      awvalid_r      <= 1'b0;
      wvalid_r       <= 1'b0;
      awaddr_r       <= '0;
      wdata_r        <= 32'd0;
      bready_r       <= 1'b0;
      arvalid_r      <= 1'b0;
      araddr_r       <= '0;
      rready_r       <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      err_code_r     <= 2'd0;
      layer_idx_r    <= 5'd0;
`ifdef CONV_SEQ_PERF_EN
      perf_idx_r     <= '0;
      perf_sum_r     <= '0;
`endif
    end else begin
      done_r       <= 1'b0;
      desc_rd_en_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            error_r    <= 1'b0;
            err_code_r <= 2'd0;
            if (num_layers == 5'd0) begin
              done_r <= 1'b1;
            end else begin
              busy_r         <= 1'b1;
              num_layers_r   <= num_layers;
              layer_idx_r    <= 5'd0;
              reg_cnt_r      <= '0;
              fetch_ph_r     <= 1'b0;
              desc_rd_addr_r <= '0;
              desc_rd_en_r   <= 1'b1;
`ifdef CONV_SEQ_PERF_EN
              perf_sum_r     <= '0;
`endif
              state_r        <= S_FETCH;
            end
          end
        end
        // Phase 0 issues the table read; phase 1 sees the word and launches AW+W together
        S_FETCH: begin
          if (!fetch_ph_r) begin
            fetch_ph_r <= 1'b1;
          end else begin
            fetch_ph_r     <= 1'b0;
            wdata_r        <= desc_rd_data;
            awaddr_r       <= csr_addr(IW'(CFG_BASE_IDX) + IW'(reg_cnt_r));
            awvalid_r      <= 1'b1;
            wvalid_r       <= 1'b1;
            desc_rd_addr_r <= desc_rd_addr_r + DAW'(1);
            state_r        <= S_WR;
          end
        end
        S_WR, S_KWR: begin
          if (m_axil.awready) awvalid_r <= 1'b0;
          if (m_axil.wready)  wvalid_r  <= 1'b0;
          if ((!awvalid_r || m_axil.awready) && (!wvalid_r || m_axil.wready)) begin
            bready_r <= 1'b1;
            state_r  <= (state_r == S_WR) ? S_WB : S_KB;
          end
        end
        S_WB: begin
          if (m_axil.bvalid) begin
            bready_r <= 1'b0;
            if (m_axil.bresp != 2'b00) begin
              error_r    <= 1'b1;
              err_code_r <= 2'd1;
              state_r    <= S_FIN;
            end else if (reg_cnt_r == RW'(NUM_CFG_REGS - 1)) begin
              awaddr_r  <= csr_addr(IW'(START_IDX));
              wdata_r   <= 32'h0000_0001;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= S_KWR;
            end else begin
              reg_cnt_r    <= reg_cnt_r + RW'(1);
              desc_rd_en_r <= 1'b1;
              state_r      <= S_FETCH;
            end
          end
        end
        S_KB: begin
          if (m_axil.bvalid) begin
            bready_r <= 1'b0;
            if (m_axil.bresp != 2'b00) begin
              error_r    <= 1'b1;
              err_code_r <= 2'd1;
              state_r    <= S_FIN;
            end else begin
              tmo_cnt_r <= '0;
              gap_cnt_r <= '0;
              state_r   <= S_GAP;
            end
          end
        end
        // Timeout is only acted on here so an in-flight read is never abandoned
        S_GAP: begin
          tmo_cnt_r <= tmo_cnt_r + TW'(1);
          if (tmo_cnt_r >= TW'(TIMEOUT)) begin
            error_r    <= 1'b1;
            err_code_r <= 2'd3;
            state_r    <= S_FIN;
          end else if (gap_cnt_r == GW'(POLL_GAP - 1)) begin
            gap_cnt_r <= '0;
            arvalid_r <= 1'b1;
            araddr_r  <= csr_addr(IW'(STATUS_IDX));
            state_r   <= S_POLL_AR;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        S_POLL_AR: begin
          tmo_cnt_r <= tmo_cnt_r + TW'(1);
          if (m_axil.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= S_POLL_R;
          end
        end
        S_POLL_R: begin
          tmo_cnt_r <= tmo_cnt_r + TW'(1);
          if (m_axil.rvalid) begin
            rready_r <= 1'b0;
            if (m_axil.rresp != 2'b00) begin
              error_r    <= 1'b1;
              err_code_r <= 2'd2;
              state_r    <= S_FIN;
            end else if (m_axil.rdata[0]) begin
`ifdef CONV_SEQ_PERF_EN
              perf_idx_r <= '0;
              arvalid_r  <= 1'b1;
              araddr_r   <= csr_addr(IW'(PERF_BASE_IDX));
              state_r    <= S_PERF_AR;
`else
              state_r    <= S_NEXT;
`endif
            end else begin
              state_r <= S_GAP;
            end
          end
        end
`ifdef CONV_SEQ_PERF_EN
        S_PERF_AR: begin
          if (m_axil.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= S_PERF_R;
          end
        end
        S_PERF_R: begin
          if (m_axil.rvalid) begin
            rready_r <= 1'b0;
            if (m_axil.rresp != 2'b00) begin
              error_r    <= 1'b1;
              err_code_r <= 2'd2;
              state_r    <= S_FIN;
            end else begin
              perf_sum_r[perf_idx_r*32 +: 32] <= sat_add32(perf_sum_r[perf_idx_r*32 +: 32], m_axil.rdata);
              if (perf_idx_r == PW'(NUM_PERF - 1)) begin
                state_r <= S_NEXT;
              end else begin
                perf_idx_r <= perf_idx_r + PW'(1);
                arvalid_r  <= 1'b1;
                araddr_r   <= csr_addr(IW'(PERF_BASE_IDX) + IW'(perf_idx_r) + IW'(1));
                state_r    <= S_PERF_AR;
              end
            end
          end
        end
`endif
        S_NEXT: begin
          layer_idx_r <= layer_idx_r + 5'd1;
          if (layer_idx_r + 5'd1 == num_layers_r) begin
            state_r <= S_FIN;
          end else begin
            reg_cnt_r    <= '0;
            desc_rd_en_r <= 1'b1;
            state_r      <= S_FETCH;
          end
        end
        S_FIN: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign desc_rd_en     = desc_rd_en_r;
  assign desc_rd_addr   = desc_rd_addr_r;
  assign m_axil.awvalid = awvalid_r;
  assign m_axil.awaddr  = awaddr_r;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.wvalid  = wvalid_r;
  assign m_axil.wdata   = wdata_r;
  assign m_axil.wstrb   = 4'hF;
  assign m_axil.bready  = bready_r;
  assign m_axil.arvalid = arvalid_r;
  assign m_axil.araddr  = araddr_r;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.rready  = rready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign err_code       = err_code_r;
  assign layer_idx      = layer_idx_r;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with a reactive AXI-lite CSR slave and descriptor table.
module tb_conv_layer_sequencer;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   num_layers;
  logic         desc_rd_en;
  logic [8:0]   desc_rd_addr;
  logic [31:0]  desc_rd_data;
  logic         busy;
  logic         done;
  logic         error;
  logic [1:0]   err_code;
  logic [4:0]   layer_idx;
  logic [127:0] perf_sum;

`ifdef CONV_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  conv_layer_sequencer_if #(.CSR_AW(8)) axil();

  conv_layer_sequencer #(.TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .start(start), .num_layers(num_layers),
    .desc_rd_en(desc_rd_en), .desc_rd_addr(desc_rd_addr), .desc_rd_data(desc_rd_data),
    .m_axil(axil), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .layer_idx(layer_idx), .perf_sum(perf_sum)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Descriptor table: word[a] = a + 100, read data one cycle after the strobe
  logic [31:0] desc_mem [0:415];
  always @(posedge clk) if (desc_rd_en) desc_rd_data <= desc_mem[desc_rd_addr];

  int          aw_stall, w_stall, polls_needed, bad_wr;
  logic [31:0] perf_val [4];
  int          wr_n, aw_hs, w_hs, ar_hs, status_reads, poll_cnt, aw_cnt, w_cnt, viol, indep;
  logic        aw_got, w_got;
  logic [7:0]  got_addr;
  logic [31:0] got_data;
  logic [7:0]  wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          perf_k;
  assign perf_k = int'(axil.araddr[7:2]) - 27;

  // CSR slave model with programmable AW/W stalls, BRESP fault and status/perf responses
  always @(posedge clk) begin
    if (rst) begin
      axil.awready <= 1'b0; axil.wready <= 1'b0; axil.bvalid <= 1'b0;
      axil.arready <= 1'b0; axil.rvalid <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
    end else begin
      if (axil.awvalid && axil.awready) begin
        axil.awready <= 1'b0; aw_cnt <= 0; aw_got <= 1'b1; got_addr <= axil.awaddr; aw_hs <= aw_hs + 1;
      end else if (axil.awvalid && !aw_got) begin
        if (aw_cnt >= aw_stall) axil.awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (axil.wvalid && axil.wready) begin
        axil.wready <= 1'b0; w_cnt <= 0; w_got <= 1'b1; got_data <= axil.wdata; w_hs <= w_hs + 1;
      end else if (axil.wvalid && !w_got) begin
        if (w_cnt >= w_stall) axil.wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !axil.bvalid) begin
        axil.bvalid <= 1'b1;
        axil.bresp  <= (wr_n == bad_wr) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
        wr_addr[wr_n] <= got_addr; wr_data[wr_n] <= got_data; wr_n <= wr_n + 1;
        if (got_addr == 8'd0) poll_cnt <= 0;
      end
      if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
      if (axil.arvalid && axil.arready) begin
        axil.arready <= 1'b0; ar_hs <= ar_hs + 1; axil.rvalid <= 1'b1; axil.rresp <= 2'b00;
        if (axil.araddr == 8'd0) begin
          status_reads <= status_reads + 1;
          poll_cnt     <= poll_cnt + 1;
          axil.rdata   <= {31'd0, (polls_needed != 0 && poll_cnt + 1 >= polls_needed)};
        end else begin
          axil.rdata <= (perf_k >= 0 && perf_k < 4) ? perf_val[perf_k[1:0]] : 32'd0;
        end
      end else if (axil.arvalid && !axil.rvalid) begin
        axil.arready <= 1'b1;
      end
      if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
    end
  end

  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [7:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;
  // Protocol monitor: a valid may not drop or change its payload before its ready
  always @(posedge clk) begin
    if (rst) begin
      p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
    end else begin
      if (p_awv && !p_awr && (!axil.awvalid || axil.awaddr != p_awaddr)) viol <= viol + 1;
      if (p_wv && !p_wr && (!axil.wvalid || axil.wdata != p_wdata)) viol <= viol + 1;
      if (p_arv && !p_arr && (!axil.arvalid || axil.araddr != p_araddr)) viol <= viol + 1;
      if (axil.awvalid && !axil.wvalid) indep <= indep + 1;
      p_awv <= axil.awvalid; p_awr <= axil.awready; p_awaddr <= axil.awaddr;
      p_wv  <= axil.wvalid;  p_wr  <= axil.wready;  p_wdata  <= axil.wdata;
      p_arv <= axil.arvalid; p_arr <= axil.arready; p_araddr <= axil.araddr;
    end
  end

  task automatic pulse_start(input logic [4:0] n);
    @(negedge clk);
    num_layers = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  function automatic logic [127:0] exp_perf(input int layers, input logic [31:0] c0);
    logic [32:0] s0;
    s0 = {1'b0, c0} * 33'(layers);
    if (!PERF) return 128'd0;
    return {32'(40 * layers), 32'(30 * layers), 32'(20 * layers), s0[32] ? 32'hFFFF_FFFF : s0[31:0]};
  endfunction

  // Checks the 27 writes of one layer starting at write index b; returns mismatch count
  function automatic int layer_writes_bad(input int b, input int layer);
    int bad = 0;
    for (int r = 0; r < 26; r++) begin
      if (wr_addr[b + r] != 8'((r + 1) * 4)) bad++;
      if (wr_data[b + r] != 32'(layer * 26 + r + 100)) bad++;
    end
    if (wr_addr[b + 26] != 8'd0 || wr_data[b + 26] != 32'd1) bad++;
    return bad;
  endfunction

  initial begin
    int base, aw0, w0, ar0, sr0, ind0, bad;
    bit seen;
    for (int i = 0; i < 416; i++) desc_mem[i] = 32'(i + 100);
    perf_val[0] = 32'd10; perf_val[1] = 32'd20; perf_val[2] = 32'd30; perf_val[3] = 32'd40;
    aw_stall = 0; w_stall = 0; polls_needed = 3; bad_wr = -1;
    rst = 1'b1; start = 1'b0; num_layers = 5'd0;
    repeat (3) @(negedge clk);
    check_val("rst busy/done/error", {busy, done, error}, 3'b000);
    check_val("rst err_code", err_code, 2'd0);
    check_val("rst layer_idx", layer_idx, 5'd0);
    check_val("rst valids", {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, desc_rd_en}, 6'd0);
    check_val("rst perf_sum", perf_sum, 128'd0);
    check_val("wstrb/prot", {axil.wstrb, axil.awprot, axil.arprot}, {4'hF, 6'd0});
    rst = 1'b0;

    // 1 layer, zero-wait, done on 3rd poll
    base = wr_n; sr0 = status_reads;
    pulse_start(5'd1);
    check_val("t1 busy", busy, 1'b1);
    wait_done(3000, seen);
    check_val("t1 done", seen, 1'b1);
    check_val("t1 error", {error, err_code}, 3'd0);
    check_val("t1 layer_idx", layer_idx, 5'd1);
    check_val("t1 busy end", busy, 1'b0);
    check_val("t1 writes", wr_n - base, 27);
    for (int r = 0; r < 26; r++) begin
      check_val($sformatf("t1 addr%0d", r), wr_addr[base + r], 8'((r + 1) * 4));
      check_val($sformatf("t1 data%0d", r), wr_data[base + r], 32'(r + 100));
    end
    check_val("t1 kick", {wr_addr[base + 26], wr_data[base + 26]}, {8'd0, 32'd1});
    check_val("t1 polls", status_reads - sr0, 3);
    check_val("t1 perf", perf_sum, exp_perf(1, 32'd10));

    // 3 layers with AW/W stalls and a start pulse during the run
    aw_stall = 5; w_stall = 2; polls_needed = 1;
    base = wr_n; aw0 = aw_hs; w0 = w_hs; ind0 = indep;
    pulse_start(5'd3);
    repeat (40) @(negedge clk);
    pulse_start(5'd1);
    wait_done(20000, seen);
    check_val("t2 done", seen, 1'b1);
    check_val("t2 layer_idx", layer_idx, 5'd3);
    check_val("t2 error", error, 1'b0);
    check_val("t2 writes", wr_n - base, 81);
    check_val("t2 aw once", aw_hs - aw0, 81);
    check_val("t2 w once", w_hs - w0, 81);
    bad = 0;
    for (int l = 0; l < 3; l++) bad += layer_writes_bad(base + 27 * l, l);
    check_val("t2 write contents", bad, 0);
    check_val("t2 indep drop", (indep - ind0) > 0, 1'b1);
    check_val("t2 perf", perf_sum, exp_perf(3, 32'd10));
    aw_stall = 0; w_stall = 0; polls_needed = 2;

    // 2 layers of perf accumulation
    pulse_start(5'd2);
    wait_done(10000, seen);
    check_val("t3 done", seen, 1'b1);
    check_val("t3 layer_idx", layer_idx, 5'd2);
    check_val("t3 perf", perf_sum, exp_perf(2, 32'd10));

    // Saturating counter 0
    perf_val[0] = 32'hFFFF_FFF0;
    pulse_start(5'd2);
    wait_done(10000, seen);
    check_val("t4 done", seen, 1'b1);
    check_val("t4 perf sat", perf_sum, exp_perf(2, 32'hFFFF_FFF0));
    perf_val[0] = 32'd10;

    // BRESP error on layer 1, write 5
    base = wr_n; bad_wr = wr_n + 27 + 5;
    pulse_start(5'd2);
    wait_done(10000, seen);
    check_val("t5 done", seen, 1'b1);
    check_val("t5 error", {error, err_code}, {1'b1, 2'd1});
    check_val("t5 layer_idx", layer_idx, 5'd1);
    check_val("t5 busy", busy, 1'b0);
    check_val("t5 writes", wr_n - base, 33);
    aw0 = aw_hs; ar0 = ar_hs;
    repeat (60) @(negedge clk);
    check_val("t5 no more aw/ar", {aw_hs - aw0, ar_hs - ar0}, 64'd0);
    check_val("t5 sticky", error, 1'b1);
    check_val("t0 no protocol violation", viol, 0);
    bad_wr = -1;

    // Status never done -> timeout
    polls_needed = 0;
    pulse_start(5'd1);
    check_val("t6 error cleared", error, 1'b0);
    wait_done(3000, seen);
    check_val("t6 done", seen, 1'b1);
    check_val("t6 error", {error, err_code}, {1'b1, 2'd3});
    check_val("t6 layer_idx", layer_idx, 5'd0);
    polls_needed = 2;

    // Reset while waiting for B
    pulse_start(5'd1);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (axil.bready) seen = 1'b1;
    end
    check_val("t7 reached WB", seen, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_val("t7 valids", {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}, 5'd0);
    check_val("t7 busy", busy, 1'b0);
    rst = 1'b0;

    // Zero-layer start: done only
    aw0 = aw_hs; ar0 = ar_hs;
    pulse_start(5'd0);
    check_val("t8 done", done, 1'b1);
    check_val("t8 busy", busy, 1'b0);
    @(negedge clk);
    check_val("t8 done pulse", done, 1'b0);
    repeat (20) @(negedge clk);
    check_val("t8 no traffic", {aw_hs - aw0, ar_hs - ar0}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
